// File: rtl/debug_controller_pkg.sv
// debug_controller_pkg: command codes, state encodings and byte-count helper for the debug controller
package debug_controller_pkg;
  localparam int DEF_PC_BITS = 10;
  localparam int DEF_DATA_ADDRS_BITS = 10;
  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;
  typedef enum logic [3:0] {
    IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, DUMP_VEC, DUMP_MEM_RD, DUMP_MEM_TX
  } state_t;
  typedef enum logic [1:0] {SND_IDLE, SND_PEND, SND_HOLD, SND_WAIT} snd_state_t;
  function automatic int byte_count(input int bits);
    return (bits + 7) / 8;
  endfunction
endpackage

// File: rtl/debug_byte_sender.sv
// debug_byte_sender: hands one byte at a time to the transmitter using its busy handshake
module debug_byte_sender
  import debug_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  output logic       o_done,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  input  logic       i_tx_busy
);
  snd_state_t state;
  // the start pulse is gated by busy so it can never coincide with a busy transmitter
  assign o_tx_start = state == SND_PEND && !i_tx_busy;
  // latch byte, start when free, skip one cycle of busy, then wait for the transmitter to drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SND_IDLE;
      o_tx_data <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        SND_IDLE: if (i_valid) begin
          o_tx_data <= i_byte;
          state <= SND_PEND;
        end
        SND_PEND: if (!i_tx_busy) state <= SND_HOLD;
        SND_HOLD: state <= SND_WAIT;
        SND_WAIT: if (!i_tx_busy) begin
          o_done <= 1'b1;
          state <= SND_IDLE;
        end
        default: state <= SND_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/debug_controller.sv
// debug_controller: byte-command debug unit that loads program words, runs/steps the core and dumps state
module debug_controller
  import debug_controller_pkg::*;
#(
  parameter int PC_BITS = DEF_PC_BITS,
  parameter int INSTRUCTION_BITS = 32,
  parameter int PROC_BITS = 32,
  parameter int DATA_ADDRS_BITS = DEF_DATA_ADDRS_BITS,
  parameter int DUMP_BITS = 1024,
  parameter int DATA_WORDS = 32,
  parameter logic [31:0] RUN_LIMIT = 32'hFFFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_valid,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_start,
  input  logic                        i_tx_busy,
  output logic                        o_enable,
  output logic                        o_write_inst_mem,
  output logic [PC_BITS-1:0]          o_inst_mem_addr,
  output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
  output logic                        o_debug_read_data,
  output logic [DATA_ADDRS_BITS-1:0]  o_debug_read_address,
  input  logic [PROC_BITS-1:0]        i_mem_data,
  input  logic [DUMP_BITS-1:0]        i_dump_vec,
  input  logic                        i_halt
);
  localparam int INST_BYTES = byte_count(INSTRUCTION_BITS);
  localparam int VEC_BYTES = byte_count(DUMP_BITS);
  localparam int PROC_BYTES = byte_count(PROC_BITS);
  localparam int VEC_W = VEC_BYTES * 8;
  state_t state;
  logic [7:0] n_left;
  logic [15:0] byte_idx;
  logic [31:0] cycle_cnt;
  logic halt_flag, rd_q, inflight, send_v, send_done;
  logic [7:0] send_byte;
  logic [VEC_W-1:0] snap;
  logic [PROC_BITS-1:0] mem_word;
  logic [VEC_W+31:0] vec_all;
  assign vec_all = {cycle_cnt, snap};
  // a retiring HALT drops enable in the same cycle so the halting cycle is not counted
  assign o_enable = (state == RUN && !i_halt) || state == STEP;
  assign o_write_inst_mem = state == LOAD_WR;
  assign o_debug_read_data = rd_q;
  debug_byte_sender u_sender (
    .clk(clk), .rst(rst), .i_byte(send_byte), .i_valid(send_v), .o_done(send_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy)
  );
  // command decode, program load, run/step control and dump sequencing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      n_left <= '0;
      byte_idx <= '0;
      cycle_cnt <= '0;
      halt_flag <= 1'b0;
      rd_q <= 1'b0;
      inflight <= 1'b0;
      send_v <= 1'b0;
      send_byte <= '0;
      snap <= '0;
      mem_word <= '0;
      o_inst_mem_addr <= '0;
      o_inst_mem_data <= '0;
      o_debug_read_address <= '0;
    end else begin
      send_v <= 1'b0;
      if (state != DUMP_VEC) snap <= VEC_W'(i_dump_vec);
      case (state)
        IDLE: begin
          byte_idx <= '0;
          if (i_rx_valid)
            state <= i_rx_data == CMD_LOAD ? LOAD_CNT :
                     i_rx_data == CMD_RUN  ? (halt_flag ? DUMP_VEC : RUN) :
                     i_rx_data == CMD_STEP ? (halt_flag ? DUMP_VEC : STEP) : IDLE;
        end
        LOAD_CNT: if (i_rx_valid) begin
          n_left <= i_rx_data;
          o_inst_mem_addr <= '0;
          state <= i_rx_data == 8'd0 ? IDLE : LOAD_BYTE;
        end
        LOAD_BYTE: if (i_rx_valid) begin
          o_inst_mem_data <= INSTRUCTION_BITS'({i_rx_data, o_inst_mem_data} >> 8);
          byte_idx <= byte_idx + 16'd1;
          if (byte_idx == 16'(INST_BYTES - 1)) state <= LOAD_WR;
        end
        LOAD_WR: begin
          byte_idx <= '0;
          n_left <= n_left - 8'd1;
          if (n_left == 8'd1) begin
            halt_flag <= 1'b0;
            cycle_cnt <= '0;
            state <= IDLE;
          end else begin
            o_inst_mem_addr <= o_inst_mem_addr + PC_BITS'(1);
            state <= LOAD_BYTE;
          end
        end
        RUN: if (i_halt) begin
          halt_flag <= 1'b1;
          state <= DUMP_VEC;
        end else begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (cycle_cnt + 32'd1 >= RUN_LIMIT) state <= DUMP_VEC;
        end
        STEP: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          state <= DUMP_VEC;
        end
        DUMP_VEC: if (!inflight) begin
          send_v <= 1'b1;
          send_byte <= 8'(vec_all >> {byte_idx, 3'b000});
          inflight <= 1'b1;
        end else if (send_done) begin
          inflight <= 1'b0;
          byte_idx <= byte_idx + 16'd1;
          if (byte_idx == 16'(VEC_BYTES + 3)) begin
            byte_idx <= '0;
            o_debug_read_address <= '0;
            rd_q <= 1'b1;
            state <= DUMP_MEM_RD;
          end
        end
        DUMP_MEM_RD: if (rd_q) rd_q <= 1'b0;
        else begin
          mem_word <= i_mem_data;
          state <= DUMP_MEM_TX;
        end
        DUMP_MEM_TX: if (!inflight) begin
          send_v <= 1'b1;
          send_byte <= 8'(mem_word >> {byte_idx, 3'b000});
          inflight <= 1'b1;
        end else if (send_done) begin
          inflight <= 1'b0;
          byte_idx <= byte_idx + 16'd1;
          if (byte_idx == 16'(PROC_BYTES - 1)) begin
            byte_idx <= '0;
            if (o_debug_read_address == DATA_ADDRS_BITS'(DATA_WORDS - 1)) begin
              o_debug_read_address <= '0;
              state <= IDLE;
            end else begin
              o_debug_read_address <= o_debug_read_address + DATA_ADDRS_BITS'(1);
              rd_q <= 1'b1;
              state <= DUMP_MEM_RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller: directed bench with a byte-stream model of the debug controller
module tb_debug_controller;
  localparam int PCB = 8, IB = 32, PB = 16, DAB = 4, DB = 20, DW = 3;
  localparam logic [31:0] RL = 32'd40;
  localparam int NVB = (DB + 7) / 8;
  localparam int NDUMP = NVB + 4 + DW * (PB / 8);
  typedef struct {logic [7:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] i_rx_data = '0, o_tx_data;
  logic i_rx_valid = 1'b0, o_tx_start, i_tx_busy, o_enable, o_write_inst_mem, o_debug_read_data;
  logic [PCB-1:0] o_inst_mem_addr;
  logic [IB-1:0] o_inst_mem_data;
  logic [DAB-1:0] o_debug_read_address;
  logic [PB-1:0] i_mem_data = '0;
  logic [DB-1:0] i_dump_vec = '0;
  logic i_halt = 1'b0, force_busy = 1'b0, prev_wr = 1'b0;
  int ubusy = 0, checks = 0, passed = 0, en_cnt = 0, win_starts = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  wr_t wrs[$];
  logic [7:0] lit_step[NDUMP] = '{8'hDE, 8'hBC, 8'h0A, 8'h01, 8'h00, 8'h00, 8'h00,
                                  8'h00, 8'hA0, 8'h11, 8'hA1, 8'h22, 8'hA2};
  always #5 clk = ~clk;
  assign i_tx_busy = ubusy != 0 || force_busy;

  debug_controller #(
    .PC_BITS(PCB), .INSTRUCTION_BITS(IB), .PROC_BITS(PB), .DATA_ADDRS_BITS(DAB),
    .DUMP_BITS(DB), .DATA_WORDS(DW), .RUN_LIMIT(RL)
  ) dut (
    .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
    .o_enable(o_enable), .o_write_inst_mem(o_write_inst_mem), .o_inst_mem_addr(o_inst_mem_addr),
    .o_inst_mem_data(o_inst_mem_data), .o_debug_read_data(o_debug_read_data),
    .o_debug_read_address(o_debug_read_address), .i_mem_data(i_mem_data),
    .i_dump_vec(i_dump_vec), .i_halt(i_halt)
  );

  function automatic logic [PB-1:0] mem_val(input int a);
    return 16'hA000 + 16'(a) * 16'h0111;
  endfunction

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
  endtask

  // transmitter model: records each started byte and stays busy for three cycles
  always @(posedge clk) begin
    if (o_tx_start) begin
      got.push_back(o_tx_data);
      ubusy <= 3;
    end else if (ubusy != 0) ubusy <= ubusy - 1;
  end

  // data memory model: one-cycle read latency
  always @(posedge clk) if (o_debug_read_data) i_mem_data <= mem_val(int'(o_debug_read_address));

  // per-cycle rules: exclusive strobes, no start while busy, single-cycle write pulses
  always @(negedge clk) if (rst === 1'b1) begin
    check(int'(o_enable) + int'(o_write_inst_mem) + int'(o_debug_read_data) <= 1 &&
          !(o_tx_start && i_tx_busy) && !(o_write_inst_mem && prev_wr), "cycle_rules",
          {59'd0, o_enable, o_write_inst_mem, o_debug_read_data, o_tx_start, i_tx_busy}, 64'd0);
    if (o_enable) en_cnt++;
    if (force_busy && o_tx_start) win_starts++;
    if (o_write_inst_mem) wrs.push_back('{o_inst_mem_addr, o_inst_mem_data});
    prev_wr = o_write_inst_mem;
  end

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    i_rx_data = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic load_word(input logic [31:0] w);
    send(8'h01, 3);
    send(8'h01, 3);
    for (int i = 0; i < 4; i++) send(8'(w >> (8 * i)), 3);
  endtask

  task automatic fill_exp(input logic [DB-1:0] dv, input logic [31:0] cnt);
    logic [NVB*8-1:0] v;
    logic [PB-1:0] m;
    v = (NVB * 8)'(dv);
    exp_q.delete();
    for (int i = 0; i < NVB; i++) exp_q.push_back(v[i*8 +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(cnt[i*8 +: 8]);
    for (int a = 0; a < DW; a++) begin
      m = mem_val(a);
      exp_q.push_back(m[7:0]);
      exp_q.push_back(m[15:8]);
    end
  endtask

  task automatic check_dump(input string nm, input int gb, input int busy_at);
    int t, bad;
    logic [DB-1:0] keep;
    bit hold_done;
    t = 0;
    bad = -1;
    hold_done = 0;
    keep = i_dump_vec;
    while (got.size() - gb < NDUMP && t < 4000) begin
      @(negedge clk);
      t++;
      if (got.size() - gb >= 1) i_dump_vec = ~keep;
      if (busy_at > 0 && !hold_done && got.size() - gb >= busy_at) begin
        force_busy = 1'b1;
        repeat (50) @(negedge clk);
        force_busy = 1'b0;
        hold_done = 1;
        t += 50;
      end
    end
    repeat (30) @(negedge clk);
    check(got.size() - gb == NDUMP, {nm, "_bytes"}, 64'(got.size() - gb), 64'(NDUMP));
    for (int i = NDUMP - 1; i >= 0; i--)
      if (gb + i >= got.size() || got[gb + i] !== exp_q[i]) bad = i;
    check(bad < 0, {nm, "_stream"}, bad < 0 ? 64'd0 : (gb + bad < got.size() ? 64'(got[gb + bad]) : 64'hFFFF),
          bad < 0 ? 64'd0 : 64'(exp_q[bad]));
  endtask

  initial begin
    int gb, eb, wb, ws, t, bad;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check({o_enable, o_write_inst_mem, o_tx_start, o_debug_read_data, o_inst_mem_addr,
           o_debug_read_address, o_inst_mem_data, o_tx_data} == '0, "reset_outputs",
          64'({o_enable, o_write_inst_mem, o_tx_start, o_debug_read_data, o_inst_mem_data}), 64'd0);
    rst = 1'b1;
    // unknown byte then an empty load
    gb = got.size();
    send(8'h7F, 3);
    send(8'h01, 3);
    send(8'h00, 10);
    check(wrs.size() == 0, "zero_load_writes", 64'(wrs.size()), 64'd0);
    check(got.size() == gb, "ignored_byte_tx", 64'(got.size() - gb), 64'd0);
    // two-word program load
    wb = wrs.size();
    send(8'h01, 3);
    send(8'h02, 3);
    for (int i = 0; i < 8; i++) send(8'(64'hDEADBEEF12345678 >> (8 * i)), 3);
    repeat (5) @(negedge clk);
    check(wrs.size() - wb == 2, "load_write_count", 64'(wrs.size() - wb), 64'd2);
    check(wrs[wb].a == 8'd0 && wrs[wb].d == 32'h12345678, "load_word0", {wrs[wb].a, wrs[wb].d}, {8'd0, 32'h12345678});
    check(wrs[wb + 1].a == 8'd1 && wrs[wb + 1].d == 32'hDEADBEEF, "load_word1",
          {wrs[wb + 1].a, wrs[wb + 1].d}, {8'd1, 32'hDEADBEEF});
    // single step with a busy stall inside the dump
    i_dump_vec = 20'hABCDE;
    fill_exp(20'hABCDE, 32'd1);
    bad = -1;
    for (int i = NDUMP - 1; i >= 0; i--) if (exp_q[i] != lit_step[i]) bad = i;
    check(bad < 0, "model_pin_step", 64'(bad), 64'hFFFFFFFFFFFFFFFF);
    gb = got.size();
    eb = en_cnt;
    ws = win_starts;
    send(8'h03, 0);
    check_dump("step_dump", gb, 5);
    check(en_cnt - eb == 1, "step_enable_cycles", 64'(en_cnt - eb), 64'd1);
    check(win_starts == ws, "busy_window_starts", 64'(win_starts - ws), 64'd0);
    // run until HALT retires on the eleventh run cycle
    load_word(32'h0);
    i_dump_vec = 20'h13579;
    fill_exp(20'h13579, 32'd10);
    gb = got.size();
    eb = en_cnt;
    send(8'h02, 0);
    t = 0;
    while (!o_enable && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(posedge clk);
    #1 i_halt = 1'b1;
    @(posedge clk);
    #1 i_halt = 1'b0;
    check_dump("run_halt_dump", gb, 0);
    check(en_cnt - eb == 10, "run_enable_cycles", 64'(en_cnt - eb), 64'd10);
    // halted core: run and step only dump
    i_dump_vec = 20'h2468A;
    fill_exp(20'h2468A, 32'd10);
    gb = got.size();
    eb = en_cnt;
    send(8'h02, 3);
    check_dump("halted_run_dump", gb, 0);
    i_dump_vec = 20'h2468A;
    gb = got.size();
    send(8'h03, 3);
    check_dump("halted_step_dump", gb, 0);
    check(en_cnt == eb, "halted_enable_cycles", 64'(en_cnt - eb), 64'd0);
    // run stopped by the cycle limit
    load_word(32'h0);
    i_dump_vec = 20'h0F0F0;
    fill_exp(20'h0F0F0, RL);
    gb = got.size();
    eb = en_cnt;
    send(8'h02, 3);
    check_dump("run_limit_dump", gb, 0);
    check(en_cnt - eb == 40, "limit_enable_cycles", 64'(en_cnt - eb), 64'd40);
    // reset in the middle of a word load, then a clean load
    send(8'h01, 3);
    send(8'h01, 3);
    send(8'hAA, 3);
    send(8'hBB, 0);
    #2 rst = 1'b0;
    #1 check({o_enable, o_write_inst_mem, o_tx_start, o_debug_read_data, o_inst_mem_addr,
              o_debug_read_address, o_inst_mem_data} == '0, "reset_mid_load",
             64'(o_inst_mem_data), 64'd0);
    @(negedge clk) rst = 1'b1;
    wb = wrs.size();
    load_word(32'h44332211);
    repeat (5) @(negedge clk);
    check(wrs.size() - wb == 1 && wrs[wb].a == 8'd0 && wrs[wb].d == 32'h44332211, "reload_after_reset",
          {wrs[wb].a, wrs[wb].d}, {8'd0, 32'h44332211});
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, checks);
    $fatal(1);
  end
endmodule
